// File: rtl/mem_port_arbiter.sv
// Shares the single processor-memory port between icache and dcache.
// The dcache has priority. A starvation counter forces the icache through
// after a bounded number of contested cycles that it loses.
// A per-tag owner table steers returning data to the cache that issued the load.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  icache_command,
    input  logic [31:0] icache_addr,
    input  logic [1:0]  dcache_command,
    input  logic [31:0] dcache_addr,
    input  logic [63:0] dcache_data,
    input  logic [3:0]  mem2proc_transaction_tag,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_data_tag,
    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    output logic        icache_grant,
    output logic        dcache_grant,
    output logic [3:0]  icache_transaction_tag,
    output logic [3:0]  dcache_transaction_tag,
    output logic [3:0]  icache_data_tag,
    output logic [3:0]  dcache_data_tag,
    output logic [63:0] icache_data,
    output logic [63:0] dcache_data_out,
    output logic [3:0]  icache_outstanding,
    output logic [3:0]  dcache_outstanding,
    output logic        tag_error
);

    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_FREE   = 2'd0,
        OWN_ICACHE = 2'd1,
        OWN_DCACHE = 2'd2
    } owner_e;

    owner_e              owner_q [NUM_TAGS];
    owner_e              owner_d [NUM_TAGS];
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [3:0]          i_out_q, i_out_d;
    logic [3:0]          d_out_q, d_out_d;
    logic                tag_error_q, tag_error_d;

    logic   icache_req_s, dcache_req_s;
    logic   icache_win_s, dcache_win_s;
    logic   ret_valid_s;
    owner_e ret_owner_s;
    logic   alloc_s;

    // Saturation-free up/down step; a simultaneous alloc and return cancel out.
    function automatic logic [3:0] count_next(input logic [3:0] cnt,
                                              input logic inc, input logic dec);
        logic [3:0] res;
        case ({inc, dec})
            2'b10:   res = cnt + 4'd1;
            2'b01:   res = cnt - 4'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

    // Pick the winner: dcache first, unless the icache has starved long enough.
    always_comb begin
        icache_req_s = (icache_command != MEM_NONE);
        dcache_req_s = (dcache_command != MEM_NONE);
        icache_win_s = 1'b0;
        dcache_win_s = 1'b0;
        if (!reset) begin
            icache_win_s = 1'b0;
            dcache_win_s = 1'b0;
        end else if (icache_req_s && dcache_req_s) begin
            icache_win_s = (starve_q == STARVE_MAX);
            dcache_win_s = (starve_q != STARVE_MAX);
        end else begin
            icache_win_s = icache_req_s;
            dcache_win_s = dcache_req_s;
        end
    end

    // Drive the memory port from the winner and hand the memory tag back to it.
    always_comb begin
        proc2mem_command       = MEM_NONE;
        proc2mem_addr          = 32'd0;
        proc2mem_data          = 64'd0;
        icache_grant           = 1'b0;
        dcache_grant           = 1'b0;
        icache_transaction_tag = 4'd0;
        dcache_transaction_tag = 4'd0;
        case ({icache_win_s, dcache_win_s})
            2'b10: begin
                proc2mem_command       = icache_command;
                proc2mem_addr          = icache_addr;
                icache_grant           = 1'b1;
                icache_transaction_tag = mem2proc_transaction_tag;
            end
            2'b01: begin
                proc2mem_command       = dcache_command;
                proc2mem_addr          = dcache_addr;
                proc2mem_data          = dcache_data;
                dcache_grant           = 1'b1;
                dcache_transaction_tag = mem2proc_transaction_tag;
            end
            default: begin
                proc2mem_command = MEM_NONE;
            end
        endcase
    end

    // Steer a returning tag to the cache that owns it (old owner on same-cycle reuse).
    always_comb begin
        ret_valid_s     = reset && (mem2proc_data_tag != 4'd0);
        ret_owner_s     = owner_q[mem2proc_data_tag];
        icache_data_tag = 4'd0;
        dcache_data_tag = 4'd0;
        if (ret_valid_s && (ret_owner_s == OWN_ICACHE)) begin
            icache_data_tag = mem2proc_data_tag;
        end else if (ret_valid_s && (ret_owner_s == OWN_DCACHE)) begin
            dcache_data_tag = mem2proc_data_tag;
        end else begin
            icache_data_tag = 4'd0;
            dcache_data_tag = 4'd0;
        end
    end

    assign icache_data        = mem2proc_data;
    assign dcache_data_out    = mem2proc_data;
    assign icache_outstanding = i_out_q;
    assign dcache_outstanding = d_out_q;
    assign tag_error          = tag_error_q;

    // Next state: free on return, then allocate, so a reissued tag gets its new owner.
    always_comb begin
        owner_d     = owner_q;
        alloc_s     = (icache_win_s || dcache_win_s) && (proc2mem_command == MEM_LOAD)
                      && (mem2proc_transaction_tag != 4'd0);
        tag_error_d = tag_error_q;
        if (ret_valid_s && (ret_owner_s == OWN_FREE)) begin
            tag_error_d = 1'b1;
        end else if (ret_valid_s) begin
            owner_d[mem2proc_data_tag] = OWN_FREE;
        end else begin
            tag_error_d = tag_error_q;
        end
        if (alloc_s) begin
            owner_d[mem2proc_transaction_tag] = icache_win_s ? OWN_ICACHE : OWN_DCACHE;
        end else begin
            owner_d[0] = owner_d[0];
        end
        i_out_d = count_next(i_out_q, alloc_s && icache_win_s,
                             ret_valid_s && (ret_owner_s == OWN_ICACHE));
        d_out_d = count_next(d_out_q, alloc_s && dcache_win_s,
                             ret_valid_s && (ret_owner_s == OWN_DCACHE));
        if (icache_req_s && dcache_req_s && dcache_win_s) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
        end else if (icache_win_s && (mem2proc_transaction_tag != 4'd0)) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q;
        end
    end

    // State registers; async reset empties the owner table and clears all counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                owner_q[i] <= OWN_FREE;
            end
            starve_q    <= '0;
            i_out_q     <= 4'd0;
            d_out_q     <= 4'd0;
            tag_error_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            i_out_q     <= i_out_d;
            d_out_q     <= d_out_d;
            tag_error_q <= tag_error_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a driver applies stimulus on the
// falling edge and queues the reference model's expected outputs; a monitor
// samples the DUT shortly after and compares against the queue.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  icache_command;
    logic [31:0] icache_addr;
    logic [1:0]  dcache_command;
    logic [31:0] dcache_addr;
    logic [63:0] dcache_data;
    logic [3:0]  mem2proc_transaction_tag;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_data_tag;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic        icache_grant, dcache_grant;
    logic [3:0]  icache_transaction_tag, dcache_transaction_tag;
    logic [3:0]  icache_data_tag, dcache_data_tag;
    logic [63:0] icache_data, dcache_data_out;
    logic [3:0]  icache_outstanding, dcache_outstanding;
    logic        tag_error;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .NUM_TAGS(16)) dut (
        .clock(clock), .reset(reset),
        .icache_command(icache_command), .icache_addr(icache_addr),
        .dcache_command(dcache_command), .dcache_addr(dcache_addr),
        .dcache_data(dcache_data),
        .mem2proc_transaction_tag(mem2proc_transaction_tag),
        .mem2proc_data(mem2proc_data), .mem2proc_data_tag(mem2proc_data_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .icache_grant(icache_grant), .dcache_grant(dcache_grant),
        .icache_transaction_tag(icache_transaction_tag),
        .dcache_transaction_tag(dcache_transaction_tag),
        .icache_data_tag(icache_data_tag), .dcache_data_tag(dcache_data_tag),
        .icache_data(icache_data), .dcache_data_out(dcache_data_out),
        .icache_outstanding(icache_outstanding),
        .dcache_outstanding(dcache_outstanding),
        .tag_error(tag_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  grants;
        logic [7:0]  ttags;
        logic [7:0]  dtags;
        logic [63:0] rdata;
        logic [7:0]  outs;
        logic        terr;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: which client owns each live tag (1 = icache, 2 = dcache).
    int owner_m[int];
    int starve_m;
    logic terr_m;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle_n  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: actual %0h required %0h", name, cycle_n, act, req);
        end
    endtask

    // Apply one cycle of stimulus and queue what the DUT must show before the next rising edge.
    task automatic step(input logic rst_v,
                        input logic [1:0] ic, input logic [31:0] ia,
                        input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                        input logic [3:0] mt, input logic [63:0] rd, input logic [3:0] rt);
        exp_t e;
        int winner;
        int ci, cd;
        @(negedge clock);
        reset = rst_v;
        icache_command = ic; icache_addr = ia;
        dcache_command = dc; dcache_addr = da; dcache_data = dd;
        mem2proc_transaction_tag = mt; mem2proc_data = rd; mem2proc_data_tag = rt;
        if (!rst_v) begin
            owner_m.delete();
            starve_m = 0;
            terr_m   = 1'b0;
        end
        ci = 0; cd = 0;
        foreach (owner_m[t]) begin
            if (owner_m[t] == 1) ci++;
            else cd++;
        end
        e.cmd = MEM_NONE; e.addr = 32'd0; e.data = 64'd0; e.grants = 2'b00;
        e.ttags = 8'd0; e.dtags = 8'd0; e.rdata = rd;
        e.outs = {4'(ci), 4'(cd)}; e.terr = terr_m;
        if (rst_v) begin
            winner = 0;
            if (ic != MEM_NONE && dc != MEM_NONE) winner = (starve_m == STARVE_LIMIT) ? 1 : 2;
            else if (ic != MEM_NONE) winner = 1;
            else if (dc != MEM_NONE) winner = 2;
            if (winner == 1) begin
                e.cmd = ic; e.addr = ia; e.grants = 2'b10; e.ttags = {mt, 4'd0};
            end else if (winner == 2) begin
                e.cmd = dc; e.addr = da; e.data = dd; e.grants = 2'b01; e.ttags = {4'd0, mt};
            end
            if (rt != 4'd0) begin
                if (owner_m.exists(int'(rt))) begin
                    if (owner_m[int'(rt)] == 1) e.dtags = {rt, 4'd0};
                    else e.dtags = {4'd0, rt};
                    owner_m.delete(int'(rt));
                end else begin
                    terr_m = 1'b1;
                end
            end
            if (winner != 0 && e.cmd == MEM_LOAD && mt != 4'd0) owner_m[int'(mt)] = winner;
            if (ic != MEM_NONE && dc != MEM_NONE && winner == 2) begin
                if (starve_m < STARVE_LIMIT) starve_m++;
            end else if (winner == 1 && mt != 4'd0) begin
                starve_m = 0;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [3:0] rt, input logic [63:0] rd);
        step(1'b1, MEM_NONE, 32'd0, MEM_NONE, 32'd0, 64'd0, 4'd0, rd, rt);
    endtask

    task automatic do_reset();
        step(1'b0, MEM_LOAD, 32'h40, MEM_LOAD, 32'h80, 64'h1, 4'd9, 64'h2, 4'd9);
    endtask

    // Monitor: compare every presented cycle against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            cycle_n++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("command", 64'(proc2mem_command), 64'(e.cmd));
                check("addr", 64'(proc2mem_addr), 64'(e.addr));
                check("wdata", proc2mem_data, e.data);
                check("grants", 64'({icache_grant, dcache_grant}), 64'(e.grants));
                check("trans_tags", 64'({icache_transaction_tag, dcache_transaction_tag}), 64'(e.ttags));
                check("data_tags", 64'({icache_data_tag, dcache_data_tag}), 64'(e.dtags));
                check("icache_data", icache_data, e.rdata);
                check("dcache_data_out", dcache_data_out, e.rdata);
                check("outstanding", 64'({icache_outstanding, dcache_outstanding}), 64'(e.outs));
                check("tag_error", 64'(tag_error), 64'(e.terr));
            end
        end
    end

    initial begin
        int keys[$];
        int cand[$];
        logic [3:0]  rt, mt;
        logic [1:0]  ic, dc;
        int r;
        reset = 1'b0;
        icache_command = MEM_NONE; icache_addr = 32'd0;
        dcache_command = MEM_NONE; dcache_addr = 32'd0; dcache_data = 64'd0;
        mem2proc_transaction_tag = 4'd0; mem2proc_data = 64'd0; mem2proc_data_tag = 4'd0;
        owner_m.delete(); starve_m = 0; terr_m = 1'b0;

        // Reset state, then a dcache load and its return.
        do_reset(); do_reset();
        step(1'b1, MEM_NONE, 32'd0, MEM_LOAD, 32'h100, 64'd0, 4'd3, 64'd0, 4'd0);
        idle(4'd0, 64'd0);
        idle(4'd3, 64'hAB);
        idle(4'd0, 64'd0);

        // Both request every cycle: four dcache wins, then the icache is forced through.
        do_reset();
        for (int i = 0; i < 6; i++)
            step(1'b1, MEM_LOAD, 32'h2000 + 32'(i * 64), MEM_LOAD, 32'h1000 + 32'(i * 64),
                 64'(i) + 64'h55, 4'(i + 1), 64'd0, 4'd0);
        for (int t = 1; t <= 6; t++) idle(4'(t), 64'h1000 + 64'(t));
        idle(4'd0, 64'd0);

        // Rejected icache load is not recorded; the retry is.
        do_reset();
        step(1'b1, MEM_LOAD, 32'h300, MEM_NONE, 32'd0, 64'd0, 4'd0, 64'd0, 4'd0);
        step(1'b1, MEM_LOAD, 32'h300, MEM_NONE, 32'd0, 64'd0, 4'd5, 64'd0, 4'd0);
        idle(4'd0, 64'd0);

        // Store tags are never owned: their return flags an error.
        do_reset();
        step(1'b1, MEM_NONE, 32'd0, MEM_STORE, 32'h400, 64'hDEAD_BEEF, 4'd7, 64'd0, 4'd0);
        idle(4'd7, 64'h77);
        idle(4'd0, 64'd0);

        // Same-cycle return and reissue of tag 2.
        do_reset();
        step(1'b1, MEM_LOAD, 32'h500, MEM_NONE, 32'd0, 64'd0, 4'd2, 64'd0, 4'd0);
        step(1'b1, MEM_NONE, 32'd0, MEM_LOAD, 32'h600, 64'd0, 4'd2, 64'h22, 4'd2);
        idle(4'd0, 64'd0);
        idle(4'd2, 64'h23);
        idle(4'd0, 64'd0);

        // Reset with three tags in flight empties the table.
        do_reset();
        step(1'b1, MEM_NONE, 32'd0, MEM_LOAD, 32'h700, 64'd0, 4'd1, 64'd0, 4'd0);
        step(1'b1, MEM_LOAD, 32'h740, MEM_NONE, 32'd0, 64'd0, 4'd2, 64'd0, 4'd0);
        step(1'b1, MEM_NONE, 32'd0, MEM_LOAD, 32'h780, 64'd0, 4'd3, 64'd0, 4'd0);
        step(1'b0, MEM_LOAD, 32'h7C0, MEM_LOAD, 32'h800, 64'h5, 4'd4, 64'h9, 4'd3);
        idle(4'd0, 64'd0);
        idle(4'd3, 64'h33);
        idle(4'd0, 64'd0);

        // Randomized traffic; memory only hands out tags that are not live.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            keys.delete();
            foreach (owner_m[t]) keys.push_back(t);
            r = int'($urandom_range(99));
            if (r < 35 && keys.size() > 0) rt = 4'(keys[$urandom_range(keys.size() - 1)]);
            else if (r < 40) rt = 4'($urandom_range(15));
            else rt = 4'd0;
            cand.delete();
            for (int t = 1; t < 16; t++)
                if (!owner_m.exists(t) || t == int'(rt)) cand.push_back(t);
            if ($urandom_range(99) < 20 || cand.size() == 0) mt = 4'd0;
            else mt = 4'(cand[$urandom_range(cand.size() - 1)]);
            ic = ($urandom_range(99) < 60) ? MEM_LOAD : MEM_NONE;
            r = int'($urandom_range(2));
            dc = (r == 0) ? MEM_NONE : ((r == 1) ? MEM_LOAD : MEM_STORE);
            step(($urandom_range(99) != 0), ic, $urandom & 32'hFFFF_FFC0,
                 dc, $urandom & 32'hFFFF_FFC0, {$urandom, $urandom},
                 mt, {$urandom, $urandom}, rt);
        end
        idle(4'd0, 64'd0);

        @(negedge clock);
        #4;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
